// File: rtl/uart_frame_filter.sv
// Pico frame parser/filter between UART RX and UART TX: clip/attenuate one sample, echo it as a response frame.
// Optional macro UART_FRAME_CHECKSUM_EN adds an XOR checksum byte to both request and response frames.
module uart_frame_filter #(
  parameter logic [7:0] HEADER_BYTE    = 8'hAA,
  parameter logic [7:0] CLIP_HIGH      = 8'd200,
  parameter logic [7:0] CLIP_LOW       = 8'd55,
  parameter int         ATTEN_SHIFT    = 1,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_50mhz,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        botao_a,
  input  logic        botao_b,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_DATA = 3'd1;
  localparam logic [2:0] ST_PROC      = 3'd2;
  localparam logic [2:0] ST_TX_HDR    = 3'd3;
  localparam logic [2:0] ST_TX_DATA   = 3'd4;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [2:0] ST_WAIT_CSUM = 3'd5;
  localparam logic [2:0] ST_TX_CSUM   = 3'd6;
`endif

  logic [2:0]       state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             a_s1, a_s2, b_s1, b_s2;
  logic             mode_a, mode_b;
  logic [7:0]       sample_p0;
  logic [7:0]       result_p1;
  logic             is_hdr;
  logic             overrun;

  function automatic logic [7:0] filter_sample(input logic [7:0] s, input logic clip_en,
                                               input logic att_en);
    logic [7:0] r;
    r = s;
    if (clip_en) begin
      if (r < CLIP_LOW)       r = CLIP_LOW;
      else if (r > CLIP_HIGH) r = CLIP_HIGH;
    end
    if (att_en) r = r >> ATTEN_SHIFT;
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign is_hdr = (rx_data == HEADER_BYTE);

`ifdef UART_FRAME_CHECKSUM_EN
  assign overrun = rx_valid && (state == ST_PROC || state == ST_TX_HDR ||
                                state == ST_TX_DATA || state == ST_TX_CSUM);
`else
  assign overrun = rx_valid && (state == ST_PROC || state == ST_TX_HDR ||
                                state == ST_TX_DATA);
`endif

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      a_s1        <= 1'b0;
      a_s2        <= 1'b0;
      b_s1        <= 1'b0;
      b_s2        <= 1'b0;
      mode_a      <= 1'b0;
      mode_b      <= 1'b0;
      frame_count <= 16'd0;
      err_count   <= 8'd0;
    end else begin
      a_s1 <= botao_a;
      a_s2 <= a_s1;
      b_s1 <= botao_b;
      b_s2 <= b_s1;
      // Bytes arriving while a response is in flight are dropped and counted.
      if (overrun) err_count <= sat_inc(err_count);
      case (state)
        ST_IDLE: begin
          if (rx_valid && is_hdr) begin
            state   <= ST_WAIT_DATA;
            mode_a  <= a_s2;
            mode_b  <= b_s2;
            tmo_cnt <= '0;
          end
        end
        ST_WAIT_DATA: begin
          // A byte in the expiry cycle takes priority over the timeout.
          if (rx_valid) begin
            if (is_hdr) begin
              mode_a  <= a_s2;
              mode_b  <= b_s2;
              tmo_cnt <= '0;
            end else begin
`ifdef UART_FRAME_CHECKSUM_EN
              state   <= ST_WAIT_CSUM;
              tmo_cnt <= '0;
`else
              state   <= ST_PROC;
`endif
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= ST_IDLE;
            err_count <= sat_inc(err_count);
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        ST_WAIT_CSUM: begin
          if (rx_valid) begin
            if (rx_data == (HEADER_BYTE ^ sample_p0)) begin
              state <= ST_PROC;
            end else begin
              state     <= ST_IDLE;
              err_count <= sat_inc(err_count);
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= ST_IDLE;
            err_count <= sat_inc(err_count);
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
`endif
        ST_PROC: state <= ST_TX_HDR;
        ST_TX_HDR: begin
          if (tx_ready) state <= ST_TX_DATA;
        end
        ST_TX_DATA: begin
          if (tx_ready) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state <= ST_TX_CSUM;
`else
            state       <= ST_IDLE;
            frame_count <= frame_count + 16'd1;
`endif
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        ST_TX_CSUM: begin
          if (tx_ready) begin
            state       <= ST_IDLE;
            frame_count <= frame_count + 16'd1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0: capture sample byte
  always_ff @(posedge clk_50mhz) begin
    if (state == ST_WAIT_DATA && rx_valid && !is_hdr) sample_p0 <= rx_data;
  end

  // Stage p1: filtered result, held stable through the TX states
  always_ff @(posedge clk_50mhz) begin
    if (state == ST_PROC) result_p1 <= filter_sample(sample_p0, mode_a, mode_b);
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      ST_TX_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE;
      end
      ST_TX_DATA: begin
        tx_valid = 1'b1;
        tx_data  = result_p1;
      end
`ifdef UART_FRAME_CHECKSUM_EN
      ST_TX_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = HEADER_BYTE ^ result_p1;
      end
`endif
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_frame_filter.sv
// Directed bench for uart_frame_filter (default two-byte frame build, short timeout).
module tb_uart_frame_filter;

  localparam int TMO = 40;

  logic        clk_50mhz = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        botao_a, botao_b;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;
  int exp_err    = 0;
  logic [7:0] txq[$];

  typedef struct {
    logic       a;
    logic       b;
    logic [7:0] smp;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[12];

  uart_frame_filter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_50mhz  (clk_50mhz),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .botao_a    (botao_a),
    .botao_b    (botao_b),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_count(frame_count),
    .err_count  (err_count)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  always @(negedge clk_50mhz) begin
    if (reset_n && tx_valid && tx_ready) txq.push_back(tx_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_50mhz);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk_50mhz);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_resp(input string nm, input logic [7:0] exp_d);
    int cyc = 0;
    logic [7:0] h, d;
    while (txq.size() < 2 && cyc < 60) begin
      @(posedge clk_50mhz);
      #1;
      cyc++;
    end
    if (txq.size() < 2) begin
      check({nm, "_resp_count"}, 16'(txq.size()), 16'd2);
      txq.delete();
    end else begin
      h = txq.pop_front();
      d = txq.pop_front();
      check({nm, "_hdr"}, {8'h0, h}, 16'h00AA);
      check({nm, "_data"}, {8'h0, d}, {8'h0, exp_d});
    end
  endtask

  task automatic wait_valid(input string nm);
    int cyc = 0;
    while (!tx_valid && cyc < 20) begin
      @(posedge clk_50mhz);
      #1;
      cyc++;
    end
    check({nm, "_tx_valid_rise"}, {15'h0, tx_valid}, 16'd1);
  endtask

  initial begin
    int stall_bad;
    vecs[0]  = '{a: 1'b0, b: 1'b0, smp: 8'hFA, exp: 8'hFA};
    vecs[1]  = '{a: 1'b1, b: 1'b0, smp: 8'hFA, exp: 8'hC8};
    vecs[2]  = '{a: 1'b1, b: 1'b0, smp: 8'h10, exp: 8'h37};
    vecs[3]  = '{a: 1'b0, b: 1'b1, smp: 8'hFA, exp: 8'h7D};
    vecs[4]  = '{a: 1'b1, b: 1'b1, smp: 8'hFA, exp: 8'h64};
    vecs[5]  = '{a: 1'b1, b: 1'b0, smp: 8'h80, exp: 8'h80};
    vecs[6]  = '{a: 1'b1, b: 1'b0, smp: 8'hC8, exp: 8'hC8};
    vecs[7]  = '{a: 1'b1, b: 1'b0, smp: 8'hC9, exp: 8'hC8};
    vecs[8]  = '{a: 1'b1, b: 1'b0, smp: 8'h36, exp: 8'h37};
    vecs[9]  = '{a: 1'b1, b: 1'b1, smp: 8'h10, exp: 8'h1B};
    vecs[10] = '{a: 1'b0, b: 1'b1, smp: 8'h01, exp: 8'h00};
    vecs[11] = '{a: 1'b0, b: 1'b0, smp: 8'h00, exp: 8'h00};

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    botao_a  = 1'b0;
    botao_b  = 1'b0;
    tx_ready = 1'b1;
    idle(3);
    check("rst_tx_valid", {15'h0, tx_valid}, 16'd0);
    check("rst_tx_data", {8'h0, tx_data}, 16'h0000);
    check("rst_frame_count", frame_count, 16'd0);
    check("rst_err_count", {8'h0, err_count}, 16'd0);
    reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < 12; i++) begin
      botao_a = vecs[i].a;
      botao_b = vecs[i].b;
      idle(3);
      send(8'hAA);
      send(vecs[i].smp);
      wait_resp($sformatf("vec%0d", i), vecs[i].exp);
      exp_frames++;
      check($sformatf("vec%0d_frames", i), frame_count, 16'(exp_frames));
      check($sformatf("vec%0d_errs", i), {8'h0, err_count}, 16'(exp_err));
    end
    botao_a = 1'b0;
    botao_b = 1'b0;
    idle(3);

    // Repeated header resyncs without error
    send(8'hAA);
    send(8'hAA);
    send(8'h64);
    wait_resp("resync", 8'h64);
    exp_frames++;
    check("resync_errs", {8'h0, err_count}, 16'(exp_err));

    // Non-header byte in IDLE is ignored
    send(8'h55);
    idle(10);
    check("idle55_no_tx", 16'(txq.size()), 16'd0);
    check("idle55_frames", frame_count, 16'(exp_frames));
    check("idle55_errs", {8'h0, err_count}, 16'(exp_err));

    // Sample arriving on the expiry cycle wins over the timeout
    send(8'hAA);
    idle(TMO - 1);
    send(8'hFA);
    wait_resp("tmo_edge", 8'hFA);
    exp_frames++;
    check("tmo_edge_errs", {8'h0, err_count}, 16'(exp_err));

    // One cycle later the timeout fires and the late byte is ignored
    send(8'hAA);
    idle(TMO);
    send(8'hFA);
    idle(10);
    exp_err++;
    check("tmo_no_tx", 16'(txq.size()), 16'd0);
    check("tmo_errs", {8'h0, err_count}, 16'(exp_err));
    send(8'hAA);
    send(8'hFA);
    wait_resp("post_tmo", 8'hFA);
    exp_frames++;
    check("post_tmo_frames", frame_count, 16'(exp_frames));

    // Back-pressure in TX_HDR, then overrun during TX_DATA
    tx_ready = 1'b0;
    send(8'hAA);
    send(8'hFA);
    wait_valid("stall");
    stall_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50mhz);
      if (!(tx_valid === 1'b1 && tx_data === 8'hAA)) stall_bad++;
    end
    @(posedge clk_50mhz);
    #1;
    check("stall_stable_violations", 16'(stall_bad), 16'd0);
    tx_ready = 1'b1;
    @(posedge clk_50mhz);
    #1;
    tx_ready = 1'b0;
    check("txdata_value", {8'h0, tx_data}, 16'h00FA);
    send(8'h33);
    exp_err++;
    check("overrun_errs", {8'h0, err_count}, 16'(exp_err));
    check("overrun_tx_valid", {15'h0, tx_valid}, 16'd1);
    check("overrun_tx_data", {8'h0, tx_data}, 16'h00FA);
    tx_ready = 1'b1;
    wait_resp("overrun", 8'hFA);
    exp_frames++;
    check("overrun_frames", frame_count, 16'(exp_frames));

    // Error counter saturation with a flood of overruns
    tx_ready = 1'b0;
    send(8'hAA);
    send(8'h20);
    wait_valid("sat");
    for (int i = 0; i < 260; i++) send(8'h11);
    check("err_saturated", {8'h0, err_count}, 16'h00FF);
    tx_ready = 1'b1;
    wait_resp("sat", 8'h20);
    exp_frames++;
    check("sat_frames", frame_count, 16'(exp_frames));

    // Asynchronous reset during TX_DATA
    tx_ready = 1'b0;
    send(8'hAA);
    send(8'hFA);
    wait_valid("rst");
    tx_ready = 1'b1;
    @(posedge clk_50mhz);
    #1;
    tx_ready = 1'b0;
    check("rst_in_txdata", {8'h0, tx_data}, 16'h00FA);
    reset_n = 1'b0;
    #1;
    check("rst_async_tx_valid", {15'h0, tx_valid}, 16'd0);
    check("rst_async_frames", frame_count, 16'd0);
    check("rst_async_errs", {8'h0, err_count}, 16'd0);
    txq.delete();
    idle(2);
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    idle(3);
    check("post_rst_no_tx", 16'(txq.size()), 16'd0);
    send(8'hAA);
    send(8'hFA);
    wait_resp("post_rst", 8'hFA);
    check("post_rst_frames", frame_count, 16'd1);
    check("post_rst_errs", {8'h0, err_count}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
